// File: rtl/l2_flush_sequencer_pkg.sv
// Shared types and default geometry for the L2 flush sequencer.
package l2_flush_sequencer_pkg;

  localparam int DEF_L2_SETS = 256;
  localparam int DEF_L2_WAYS = 8;
  localparam int DEF_N_MSHR  = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_STEP = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } l2_flush_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/l2_flush_sequencer.sv
// Walks every (set, way) of the L2 issuing one flush step per line, then waits for
// outstanding writebacks to drain and pulses flush_done.
//
// state     | meaning
// IDLE      | ready for a flush command
// ISSUE     | offering the current set/way step to l2_fsm
// WAIT_STEP | step accepted, waiting for step_done
// DRAIN     | walk finished, waiting for all MSHRs free
// DONE      | one-cycle completion pulse
module l2_flush_sequencer
  import l2_flush_sequencer_pkg::*;
#(
  parameter int L2_SETS = DEF_L2_SETS,
  parameter int L2_WAYS = DEF_L2_WAYS,
  parameter int N_MSHR  = DEF_N_MSHR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         l2_flush_valid,
  input  logic                         l2_flush_i,
  output logic                         l2_flush_ready,
  output logic                         flush_req_valid,
  input  logic                         flush_req_ready,
  output logic [$clog2(L2_SETS)-1:0]   flush_set,
  output logic [$clog2(L2_WAYS)-1:0]   flush_way,
  output logic                         is_flush_all,
  input  logic                         step_done,
  input  logic                         step_wb,
  input  logic                         pause,
  input  logic [$clog2(N_MSHR):0]      mshr_cnt,
  output logic                         ongoing_flush,
  output logic                         flush_done,
  output logic [15:0]                  flush_wb_cnt
);

  localparam int L2_SET_BITS  = $clog2(L2_SETS);
  localparam int L2_WAY_BITS  = $clog2(L2_WAYS);
  localparam int REQS_BITS_P1 = $clog2(N_MSHR) + 1;

  localparam logic [L2_SET_BITS-1:0]  LAST_SET = L2_SET_BITS'(L2_SETS - 1);
  localparam logic [L2_WAY_BITS-1:0]  LAST_WAY = L2_WAY_BITS'(L2_WAYS - 1);
  localparam logic [REQS_BITS_P1-1:0] ALL_FREE = REQS_BITS_P1'(N_MSHR);

  l2_flush_state_t state, next_state;
  logic [L2_SET_BITS-1:0] set_q;
  logic [L2_WAY_BITS-1:0] way_q;
  logic [15:0]            wb_cnt_q;
  logic                   all_q;
  logic                   req_held;
  logic                   req_valid;
  logic                   last_line;

  assign last_line = (set_q == LAST_SET) && (way_q == LAST_WAY);

  always_comb begin
    next_state = state;
    req_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (l2_flush_valid) next_state = ISSUE;
      end
      ISSUE: begin
        // Once offered, the step stays valid regardless of pause/MSHR changes.
        req_valid = req_held || (!pause && (mshr_cnt != '0));
        if (req_valid && flush_req_ready) next_state = WAIT_STEP;
      end
      WAIT_STEP: begin
        if (step_done) next_state = last_line ? DRAIN : ISSUE;
      end
      DRAIN: begin
        if (mshr_cnt == ALL_FREE) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      set_q    <= '0;
      way_q    <= '0;
      wb_cnt_q <= '0;
      all_q    <= 1'b0;
      req_held <= 1'b0;
    end else begin
      state    <= next_state;
      req_held <= (state == ISSUE) && req_valid && !flush_req_ready;
      if (state == IDLE && l2_flush_valid) begin
        all_q    <= l2_flush_i;
        set_q    <= '0;
        way_q    <= '0;
        wb_cnt_q <= '0;
      end else if (state == WAIT_STEP && step_done) begin
        if (step_wb) wb_cnt_q <= sat_inc16(wb_cnt_q);
        if (way_q != LAST_WAY) begin
          way_q <= way_q + 1'b1;
        end else if (set_q != LAST_SET) begin
          way_q <= '0;
          set_q <= set_q + 1'b1;
        end
      end
    end
  end

  assign l2_flush_ready  = (state == IDLE);
  assign flush_req_valid = req_valid;
  assign flush_set       = set_q;
  assign flush_way       = way_q;
  assign is_flush_all    = all_q;
  assign ongoing_flush   = (state == ISSUE) || (state == WAIT_STEP) || (state == DRAIN);
  assign flush_done      = (state == DONE);
  assign flush_wb_cnt    = wb_cnt_q;

endmodule

// File: tb/tb_l2_flush_sequencer.sv
// Directed bench for l2_flush_sequencer with SETS=4, WAYS=2, N_MSHR=2.
module tb_l2_flush_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        l2_flush_valid = 1'b0;
  logic        l2_flush_i = 1'b0;
  logic        l2_flush_ready;
  logic        flush_req_valid;
  logic        flush_req_ready = 1'b1;
  logic [1:0]  flush_set;
  logic        flush_way;
  logic        is_flush_all;
  logic        step_done = 1'b0;
  logic        step_wb = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  mshr_cnt = 2'd2;
  logic        ongoing_flush;
  logic        flush_done;
  logic [15:0] flush_wb_cnt;

  int n_checks = 0;
  int n_errors = 0;

  l2_flush_sequencer #(.L2_SETS(4), .L2_WAYS(2), .N_MSHR(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .l2_flush_valid  (l2_flush_valid),
    .l2_flush_i      (l2_flush_i),
    .l2_flush_ready  (l2_flush_ready),
    .flush_req_valid (flush_req_valid),
    .flush_req_ready (flush_req_ready),
    .flush_set       (flush_set),
    .flush_way       (flush_way),
    .is_flush_all    (is_flush_all),
    .step_done       (step_done),
    .step_wb         (step_wb),
    .pause           (pause),
    .mshr_cnt        (mshr_cnt),
    .ongoing_flush   (ongoing_flush),
    .flush_done      (flush_done),
    .flush_wb_cnt    (flush_wb_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_flush(input logic all_lines, input string tag);
    l2_flush_valid = 1'b1;
    l2_flush_i     = all_lines;
    #1;
    chk({tag, "_cmd_ready"}, 32'(l2_flush_ready), 1);
    tick();
    l2_flush_valid = 1'b0;
    #1;
    chk({tag, "_ongoing"}, 32'(ongoing_flush), 1);
    chk({tag, "_ready_busy"}, 32'(l2_flush_ready), 0);
    chk({tag, "_all"}, 32'(is_flush_all), 32'(all_lines));
    chk({tag, "_wb_clr"}, 32'(flush_wb_cnt), 0);
  endtask

  task automatic wait_req(input int s, input int w, input string tag);
    int n = 0;
    while (!flush_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(flush_req_valid), 1);
    chk({tag, "_set"}, 32'(flush_set), 32'(s));
    chk({tag, "_way"}, 32'(flush_way), 32'(w));
  endtask

  // Called with a request valid and flush_req_ready high: the next edge accepts it.
  // step_done arrives two edges after the accept edge.
  task automatic accept_step(input logic wb, input logic early, input string tag);
    if (early) begin
      step_done = 1'b1;
      step_wb   = 1'b1;
    end
    tick();
    step_done = 1'b0;
    step_wb   = 1'b0;
    #1;
    chk({tag, "_wait_valid"}, 32'(flush_req_valid), 0);
    chk({tag, "_wait_ongoing"}, 32'(ongoing_flush), 1);
    tick();
    step_done = 1'b1;
    step_wb   = wb;
    tick();
    step_done = 1'b0;
    step_wb   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset state
    tick();
    chk("rst_ready", 32'(l2_flush_ready), 1);
    chk("rst_req_valid", 32'(flush_req_valid), 0);
    chk("rst_ongoing", 32'(ongoing_flush), 0);
    chk("rst_done", 32'(flush_done), 0);
    chk("rst_wb_cnt", 32'(flush_wb_cnt), 0);
    chk("rst_all", 32'(is_flush_all), 0);
    chk("rst_set", 32'(flush_set), 0);
    tick();
    rst = 1'b1;
    tick();

    // 2 + 5a. full walk, writebacks on steps 1,4,7, ignored early step_done on step 2
    start_flush(1'b1, "f1");
    l2_flush_valid = 1'b1;
    #1;
    chk("f1_backpressure", 32'(l2_flush_ready), 0);
    for (int i = 0; i < 8; i++) begin
      wait_req(i / 2, i % 2, $sformatf("f1_s%0d", i));
      accept_step((i == 1) || (i == 4) || (i == 7), (i == 2), $sformatf("f1_s%0d", i));
      if (i == 0) begin
        chk("f1_backpressure2", 32'(l2_flush_ready), 0);
        l2_flush_valid = 1'b0;
      end
    end
    chk("f1_drain_done", 32'(flush_done), 0);
    chk("f1_drain_ongoing", 32'(ongoing_flush), 1);
    tick();
    chk("f1_done", 32'(flush_done), 1);
    chk("f1_done_ongoing", 32'(ongoing_flush), 0);
    chk("f1_wb_cnt", 32'(flush_wb_cnt), 3);
    tick();
    chk("f1_done_pulse_end", 32'(flush_done), 0);
    chk("f1_idle_ready", 32'(l2_flush_ready), 1);
    chk("f1_wb_hold", 32'(flush_wb_cnt), 3);

    // 3 + 4 + 5b. second flush: pause/hold on first step, drain stall at the end
    pause = 1'b1;
    start_flush(1'b0, "f2");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("f2_pause_%0d", i), 32'(flush_req_valid), 0);
      tick();
    end
    flush_req_ready = 1'b0;
    pause = 1'b0;
    #1;
    chk("f2_unpause_valid", 32'(flush_req_valid), 1);
    tick();
    pause = 1'b1;
    #1;
    chk("f2_hold_pause_valid", 32'(flush_req_valid), 1);
    chk("f2_hold_set", 32'(flush_set), 0);
    chk("f2_hold_way", 32'(flush_way), 0);
    tick();
    mshr_cnt = 2'd0;
    #1;
    chk("f2_hold_mshr_valid", 32'(flush_req_valid), 1);
    chk("f2_hold_mshr_way", 32'(flush_way), 0);
    tick();
    flush_req_ready = 1'b1;
    pause = 1'b0;
    mshr_cnt = 2'd2;
    #1;
    accept_step(1'b0, 1'b0, "f2_s0");
    for (int i = 1; i < 8; i++) begin
      wait_req(i / 2, i % 2, $sformatf("f2_s%0d", i));
      accept_step(1'b0, 1'b0, $sformatf("f2_s%0d", i));
    end
    mshr_cnt = 2'd1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("f2_drain_hold_%0d", i), 32'(flush_done), 0);
      tick();
    end
    chk("f2_drain_ongoing", 32'(ongoing_flush), 1);
    mshr_cnt = 2'd2;
    tick();
    chk("f2_done", 32'(flush_done), 1);
    chk("f2_wb_cnt", 32'(flush_wb_cnt), 0);
    tick();
    chk("f2_done_pulse_end", 32'(flush_done), 0);
    chk("f2_idle_ready", 32'(l2_flush_ready), 1);

    // 6. async reset mid-flush at set 2
    start_flush(1'b1, "f3");
    for (int i = 0; i < 4; i++) begin
      wait_req(i / 2, i % 2, $sformatf("f3_s%0d", i));
      accept_step(1'b1, 1'b0, $sformatf("f3_s%0d", i));
    end
    wait_req(2, 0, "f3_s4");
    #2 rst = 1'b0;
    #1;
    chk("f3_rst_ready", 32'(l2_flush_ready), 1);
    chk("f3_rst_ongoing", 32'(ongoing_flush), 0);
    chk("f3_rst_valid", 32'(flush_req_valid), 0);
    chk("f3_rst_set", 32'(flush_set), 0);
    chk("f3_rst_wb", 32'(flush_wb_cnt), 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("f3_post_done_%0d", i), 32'(flush_done), 0);
      chk($sformatf("f3_post_valid_%0d", i), 32'(flush_req_valid), 0);
    end
    chk("f3_post_ready", 32'(l2_flush_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
